// File: rtl/cube_pkg.sv
// Shared constants, FSM state type and row-address helpers for the cube frame store.
package cube_pkg;

    localparam int unsigned CUBE_ROWS = 64;
    localparam int unsigned ROW_W     = 8;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned HOLD_W    = 8;
    localparam int unsigned LAYER_W   = 3;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2
    } ctrl_state_t;

    // Layer index of a row address (upper three bits).
    function automatic logic [LAYER_W-1:0] addr_layer(input logic [ADDR_W-1:0] addr);
        return addr[5:3];
    endfunction

    // Row-within-layer index of a row address (lower three bits).
    function automatic logic [LAYER_W-1:0] addr_row(input logic [ADDR_W-1:0] addr);
        return addr[2:0];
    endfunction

    // Compose a row address from layer and row-within-layer.
    function automatic logic [ADDR_W-1:0] addr_join(input logic [LAYER_W-1:0] layer,
                                                    input logic [LAYER_W-1:0] row);
        return {layer, row};
    endfunction

endpackage

// File: rtl/cube_bank_ram.sv
// One 64x8 frame bank: a synchronous write port and two combinational read ports.
module cube_bank_ram
    import cube_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ROW_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [ROW_W-1:0]  rdata_a_c,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [ROW_W-1:0]  rdata_b_c
);

    logic [ROW_W-1:0] mem [CUBE_ROWS];

    // Row write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Scanner-side and copy-side read ports.
    always_comb begin
        rdata_a_c = mem[raddr_a];
        rdata_b_c = mem[raddr_b];
    end

endmodule

// File: rtl/cube_frame_ctrl.sv
// Double-buffered frame-store controller: tear-free bank swaps at scanner wrap,
// minimum display time per frame, optional copy of the shown frame into the back bank.
module cube_frame_ctrl
    import cube_pkg::*;
#(
    parameter bit          COPY_ON_SWAP = 1'b1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ROW_W-1:0]  wr_data,
    input  logic              commit,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ROW_W-1:0]  rd_data,
    input  logic              scan_wrap,
    input  logic [HOLD_W-1:0] min_scans,
    output logic              swap_pulse,
    output logic              front_sel,
    output logic [CNT_W-1:0]  frame_count
);

    ctrl_state_t       state;
    ctrl_state_t       state_nxt;
    logic [ADDR_W-1:0] copy_idx;
    logic [ADDR_W-1:0] copy_idx_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_inc;
    logic [HOLD_W-1:0] min_eff;
    logic              blank;
    logic              swap_go;

    logic              back_we;
    logic [ADDR_W-1:0] back_waddr;
    logic [ROW_W-1:0]  back_wdata;
    logic              bank0_we;
    logic              bank1_we;
    logic [ROW_W-1:0]  bank0_rd_a;
    logic [ROW_W-1:0]  bank0_rd_b;
    logic [ROW_W-1:0]  bank1_rd_a;
    logic [ROW_W-1:0]  bank1_rd_b;
    logic [ROW_W-1:0]  copy_data;

    // Swap decision: saturated wrap count including this wrap against the effective minimum.
    always_comb begin
        hold_inc = (hold_cnt == {HOLD_W{1'b1}}) ? hold_cnt : hold_cnt + HOLD_W'(1);
        min_eff  = (min_scans == '0) ? HOLD_W'(1) : min_scans;
        swap_go  = (state == PENDING) && scan_wrap && (hold_inc >= min_eff);
    end

    // Next-state and copy index sequencing.
    always_comb begin
        state_nxt    = state;
        copy_idx_nxt = copy_idx;
        case (state)
            FILL: begin
                if (commit) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (swap_go) begin
                    state_nxt = COPY_ON_SWAP ? COPY : FILL;
                end
            end
            COPY: begin
                copy_idx_nxt = copy_idx + ADDR_W'(1);
                if (copy_idx == ADDR_W'(CUBE_ROWS - 1)) begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt    = FILL;
                copy_idx_nxt = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold counter, bank select, frame counter and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            copy_idx    <= '0;
            hold_cnt    <= '0;
            front_sel   <= 1'b0;
            frame_count <= '0;
            swap_pulse  <= 1'b0;
            blank       <= 1'b1;
            wr_ready    <= 1'b1;
        end else begin
            copy_idx    <= copy_idx_nxt;
            if (swap_go) begin
                hold_cnt <= '0;
            end else if (scan_wrap) begin
                hold_cnt <= hold_inc;
            end
            front_sel   <= front_sel ^ swap_go;
            frame_count <= frame_count + CNT_W'(swap_go);
            swap_pulse  <= swap_go;
            blank       <= blank & ~swap_go;
            wr_ready    <= (state_nxt == FILL);
        end
    end

    // Back-bank write source: generator writes in FILL, front-bank copy in COPY.
    always_comb begin
        copy_data  = front_sel ? bank1_rd_b : bank0_rd_b;
        back_we    = 1'b0;
        back_waddr = wr_addr;
        back_wdata = wr_data;
        if (state == COPY) begin
            back_we    = 1'b1;
            back_waddr = copy_idx;
            back_wdata = copy_data;
        end else if (state == FILL) begin
            back_we    = wr_en;
        end
        bank0_we = back_we &  front_sel;
        bank1_we = back_we & ~front_sel;
    end

    // Scanner read path; blanked until the first frame is shown.
    always_comb begin
        rd_data = '0;
        if (!blank) begin
            rd_data = front_sel ? bank1_rd_a : bank0_rd_a;
        end
    end

    cube_bank_ram u_bank0 (
        .clk       (clk),
        .we        (bank0_we),
        .waddr     (back_waddr),
        .wdata     (back_wdata),
        .raddr_a   (rd_addr),
        .rdata_a_c (bank0_rd_a),
        .raddr_b   (copy_idx),
        .rdata_b_c (bank0_rd_b)
    );

    cube_bank_ram u_bank1 (
        .clk       (clk),
        .we        (bank1_we),
        .waddr     (back_waddr),
        .wdata     (back_wdata),
        .raddr_a   (rd_addr),
        .rdata_a_c (bank1_rd_a),
        .raddr_b   (copy_idx),
        .rdata_b_c (bank1_rd_b)
    );

endmodule

// File: tb/tb_cube_frame_ctrl.sv
// Scoreboard bench for cube_frame_ctrl: expected swaps are queued by the stimulus and
// checked by a monitor on swap_pulse; displayed frame contents are checked against a model.
module tb_cube_frame_ctrl;

    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [5:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             commit;
    logic             wr_ready;
    logic [5:0]       rd_addr;
    logic [7:0]       rd_data;
    logic             scan_wrap;
    logic [7:0]       min_scans;
    logic             swap_pulse;
    logic             front_sel;
    logic [CNT_W-1:0] frame_count;

    typedef struct packed {
        logic             fs;
        logic [CNT_W-1:0] cnt;
    } swap_exp_t;

    swap_exp_t        exp_q[$];
    int               vectors = 0;
    int               miscompares = 0;
    logic [7:0]       m_front [64];
    logic [7:0]       m_back  [64];
    logic             m_fs;
    logic [CNT_W-1:0] m_cnt;
    logic             m_blank;

    cube_frame_ctrl #(.COPY_ON_SWAP(1'b1), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .wr_ready    (wr_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .scan_wrap   (scan_wrap),
        .min_scans   (min_scans),
        .swap_pulse  (swap_pulse),
        .front_sel   (front_sel),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every swap pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        swap_exp_t e;
        if (swap_pulse === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_swap: got front_sel=%0d frame_count=%0d, expected no swap",
                         front_sel, frame_count);
            end else begin
                e = exp_q.pop_front();
                if ({front_sel, frame_count} !== e) begin
                    miscompares++;
                    $display("FAIL swap_state: got front_sel=%0d frame_count=%0d, expected front_sel=%0d frame_count=%0d",
                             front_sel, frame_count, e.fs, e.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 6'(a);
        wr_data = d;
        m_back[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic pulse_wrap();
        scan_wrap = 1'b1;
        tick();
        scan_wrap = 1'b0;
        tick();
    endtask

    task automatic read_row(input string name, input int a, input logic [7:0] exp);
        rd_addr = 6'(a);
        tick();
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic sweep(input string name);
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            tick();
            check($sformatf("%s_row%0d", name, a), 32'(rd_data),
                  m_blank ? 32'd0 : 32'(m_front[a]));
        end
    endtask

    // Copy window: wr_ready must stay low exactly 64 cycles; writes attempted late in it are dropped.
    task automatic copy_phase(input string name);
        int n;
        n = 0;
        while (wr_ready !== 1'b1 && n < 200) begin
            wr_en   = (n >= 40 && n < 60);
            wr_addr = 6'd20;
            wr_data = 8'h55;
            n++;
            tick();
        end
        wr_en = 1'b0;
        check({name, "_copy_len"}, 32'(n), 32'd64);
    endtask

    task automatic wrap_expect_swap(input string name);
        swap_exp_t e;
        m_fs    = ~m_fs;
        m_cnt   = m_cnt + 1'b1;
        m_blank = 1'b0;
        e.fs    = m_fs;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
        scan_wrap = 1'b1;
        tick();
        scan_wrap = 1'b0;
        m_front = m_back;
        m_back  = m_front;
        copy_phase(name);
        check({name, "_swap_seen"}, 32'(exp_q.size()), 32'd0);
        sweep(name);
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        commit    = 1'b0;
        rd_addr   = '0;
        scan_wrap = 1'b0;
        min_scans = 8'd1;
        m_fs      = 1'b0;
        m_cnt     = '0;
        m_blank   = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_front_sel", 32'(front_sel), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_swap_pulse", 32'(swap_pulse), 32'd0);
        sweep("rst");

        // First frame: rows k -> A0|k, min_scans=1, single wrap swaps
        for (int k = 0; k < 64; k++) begin
            wr(k, 8'hA0 | 8'(k));
        end
        do_commit();
        check("s1_pend_wr_ready", 32'(wr_ready), 32'd0);
        wrap_expect_swap("s1");
        read_row("s1_row5", 5, 8'hA5);
        check("s1_front_sel", 32'(front_sel), 32'd1);
        check("s1_frame_count", 32'(frame_count), 32'd1);

        // Incremental edit of row 10 only
        wr(10, 8'hFF);
        do_commit();
        wrap_expect_swap("s2");
        read_row("s2_row10", 10, 8'hFF);
        read_row("s2_row20", 20, 8'hB4);

        // Write and commit in the same cycle
        wr_en   = 1'b1;
        wr_addr = 6'd63;
        wr_data = 8'h3C;
        commit  = 1'b1;
        m_back[63] = 8'h3C;
        tick();
        wr_en  = 1'b0;
        commit = 1'b0;
        check("s3_pend_wr_ready", 32'(wr_ready), 32'd0);
        wrap_expect_swap("s3");
        read_row("s3_row63", 63, 8'h3C);
        read_row("s3_row10", 10, 8'hFF);

        // min_scans=3: no swap on wraps 1 and 2; writes and a second commit in PENDING ignored
        min_scans = 8'd3;
        do_commit();
        pulse_wrap();
        check("s4_wrap1_wr_ready", 32'(wr_ready), 32'd0);
        check("s4_wrap1_frame_count", 32'(frame_count), 32'd3);
        wr_en   = 1'b1;
        wr_addr = 6'd0;
        wr_data = 8'h77;
        commit  = 1'b1;
        tick();
        wr_en  = 1'b0;
        commit = 1'b0;
        pulse_wrap();
        check("s4_wrap2_wr_ready", 32'(wr_ready), 32'd0);
        check("s4_wrap2_front_sel", 32'(front_sel), 32'd1);
        wrap_expect_swap("s4");
        check("s4_frame_count_wrapped", 32'(frame_count), 32'd0);

        // Wraps in FILL with nothing committed: no swap, but hold accumulates
        min_scans = 8'd2;
        pulse_wrap();
        pulse_wrap();
        check("s5_fill_wr_ready", 32'(wr_ready), 32'd1);
        do_commit();
        wrap_expect_swap("s5");

        // min_scans=0 acts as 1
        min_scans = 8'd0;
        do_commit();
        wrap_expect_swap("s6");

        // Reset while PENDING with hold satisfied abandons the commit
        min_scans = 8'd1;
        wr(7, 8'h11);
        pulse_wrap();
        pulse_wrap();
        do_commit();
        check("r_pend_wr_ready", 32'(wr_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        scan_wrap = 1'b1;
        tick();
        scan_wrap = 1'b0;
        m_fs    = 1'b0;
        m_cnt   = '0;
        m_blank = 1'b1;
        repeat (3) tick();
        check("r_wr_ready", 32'(wr_ready), 32'd1);
        check("r_front_sel", 32'(front_sel), 32'd0);
        check("r_frame_count", 32'(frame_count), 32'd0);
        check("r_swap_pulse", 32'(swap_pulse), 32'd0);
        sweep("r");

        repeat (5) tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cube_frame_ctrl.md
Name: cube_frame_ctrl

Overview:
- Double-buffered frame-store controller between animation generators (writer side) and the 8x8x8 cube row scanner (reader side).
- The writer fills a back bank of 64 rows x 8 bits, then commits. The controller swaps banks only at a scanner wrap (row 63 -> 0), and only after the current frame has been shown for at least min_scans full scans.
- This gives tear-free frames and a programmable animation rate.
- Optionally copies the newly shown frame into the new back bank, so generators can edit incrementally.

Parameters:
- COPY_ON_SWAP, 1, when 1 the new back bank is preloaded from the new front bank after each swap.
- CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write one row into the back bank
- wr_addr  in  6  row index; [5:3] layer, [2:0] row within layer
- wr_data  in  8  LED bits of that row
- commit  in  1  single-cycle pulse: back bank complete, request swap
- wr_ready  out  1  back bank writable and commit accepted
- rd_addr  in  6  scanner row index
- rd_data  out  8  front-bank row at rd_addr (combinational)
- scan_wrap  in  1  single-cycle pulse from scanner when its row counter wraps 63 -> 0
- min_scans  in  8  minimum full scans per frame; 0 is treated as 1
- swap_pulse  out  1  registered single-cycle pulse, the cycle after a swap
- front_sel  out  1  bank currently displayed
- frame_count  out  CNT_W  number of swaps since reset, wraps

Behaviour:
- Reset values: state FILL, front_sel=0, hold_cnt=0, frame_count=0, swap_pulse=0, blank=1, copy_idx=0.
- Bank RAM contents are not reset. While blank=1, rd_data=0; blank clears on the first swap.
- State FILL:
  - wr_ready=1.
  - wr_en writes wr_data to back bank (!front_sel) at wr_addr on the clock edge.
  - commit moves to PENDING. wr_en and commit in the same cycle: the write is performed, then commit takes effect.
- State PENDING:
  - wr_ready=0; wr_en and commit are ignored.
- hold_cnt:
  - 8-bit, saturating at 255, counts scan_wrap pulses since the last swap, in all states.
- Swap condition:
  - State is PENDING, scan_wrap=1, and sat(hold_cnt+1) >= max(min_scans,1).
  - On that edge: front_sel toggles, hold_cnt<=0, frame_count++, blank<=0, swap_pulse=1 on the next cycle.
  - Next state is COPY if COPY_ON_SWAP, else FILL.
- Swap visibility: the swap edge coincides with the scanner moving to row 0, so row 0 of the new frame is the first row read from the new bank. No frame is ever displayed partially.
- scan_wrap in FILL or COPY only advances hold_cnt. A commit arriving after hold has expired swaps at the next wrap.
- State COPY:
  - wr_ready=0.
  - Each cycle: back[copy_idx] <= front[copy_idx], copy_idx++.
  - Runs for 64 cycles (idx 0..63), then copy_idx<=0 and state -> FILL.
  - Uses a second front-bank read port, so rd_data is undisturbed.
  - scan_wrap during COPY cannot cause a swap.
- min_scans is sampled continuously. Changing it while in PENDING takes effect at the next wrap.
- rst mid-COPY or mid-PENDING: the pending commit is abandoned, and both state and counters return to their reset values.
- frame_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package cube_pkg holds:
  - constants CUBE_ROWS=64, ROW_W=8, ADDR_W=6
  - enum ctrl_state_t {FILL, PENDING, COPY}
  - row index split helpers (layer = addr[5:3], row = addr[2:0])
- One sub-module, cube_bank_ram: 64x8 RAM with one synchronous write port and two combinational read ports, instantiated twice.
- The controller FSM, hold counter and copy engine live in cube_frame_ctrl.

Test Plan:
- Reset, rd_addr sweep 0..63 -> rd_data=0 throughout; wr_ready=1; front_sel=0; frame_count=0.
- Write rows k -> 8'hA0|k (k=0..63), commit, min_scans=1, one scan_wrap -> swap_pulse one cycle after the wrap; front_sel=1; rd_data at addr 5 = 8'hA5; frame_count=1.
- min_scans=3, commit right after a swap, pulse scan_wrap 3 times -> no swap on wraps 1 and 2, swap exactly on wrap 3; wr_ready stays 0 throughout.
- COPY_ON_SWAP=1:
  - After a swap, wr_ready low for exactly 64 cycles.
  - Then write only row 10 = 8'hFF and commit -> after the next swap, row 10 = 8'hFF and rows != 10 equal the prior frame.
  - Writes attempted during COPY have no effect.
- wr_en plus commit in the same cycle (addr 63, data 8'h3C) -> row 63 = 8'h3C after the swap.
- A second commit in PENDING is ignored: exactly one swap occurs.
- Assert rst while in PENDING with hold satisfied, then pulse scan_wrap -> no swap; all outputs return to their reset values.
- min_scans=0 behaves identically to min_scans=1.
